// File: rtl/csr_commit_pipe_if.sv
// Bundles the issue, CSR-result, memory-exception and writeback signals of the commit pipe.
// No latency of its own; it is only a signal container.
// No backpressure: the issue side must only issue when downstream can accept.
interface csr_commit_pipe_if;
    // issue side
    logic        opcode_valid;
    logic [31:0] opcode_opcode;
    logic [31:0] opcode_pc;
    logic [4:0]  opcode_rd_idx;
    // registered CSR unit result, valid the cycle after issue
    logic [31:0] csr_result_e1_value;
    logic        csr_result_e1_write;
    logic [31:0] csr_result_e1_wdata;
    logic [5:0]  csr_result_e1_exception;
    // late LSU exception for the instruction in E2
    logic [5:0]  mem_exception_e2;
    logic [31:0] mem_addr_e2;
    logic        squash;
    // CSR writeback / exception commit bus
    logic        csr_writeback_write;
    logic [11:0] csr_writeback_waddr;
    logic [31:0] csr_writeback_wdata;
    logic [5:0]  csr_writeback_exception;
    logic [31:0] csr_writeback_exception_pc;
    logic [31:0] csr_writeback_exception_addr;
    // register-file writeback
    logic        wb_valid;
    logic [4:0]  wb_rd_idx;
    logic        wb_rd_we;
    logic [31:0] wb_result;
    logic        interrupt_inhibit;

    // Issue/execute side drives the pipe's inputs and observes its outputs.
    modport master (
        output opcode_valid, opcode_opcode, opcode_pc, opcode_rd_idx,
        output csr_result_e1_value, csr_result_e1_write, csr_result_e1_wdata,
        output csr_result_e1_exception, mem_exception_e2, mem_addr_e2, squash,
        input  csr_writeback_write, csr_writeback_waddr, csr_writeback_wdata,
        input  csr_writeback_exception, csr_writeback_exception_pc,
        input  csr_writeback_exception_addr,
        input  wb_valid, wb_rd_idx, wb_rd_we, wb_result, interrupt_inhibit
    );

    // The commit pipe itself.
    modport slave (
        input  opcode_valid, opcode_opcode, opcode_pc, opcode_rd_idx,
        input  csr_result_e1_value, csr_result_e1_write, csr_result_e1_wdata,
        input  csr_result_e1_exception, mem_exception_e2, mem_addr_e2, squash,
        output csr_writeback_write, csr_writeback_waddr, csr_writeback_wdata,
        output csr_writeback_exception, csr_writeback_exception_pc,
        output csr_writeback_exception_addr,
        output wb_valid, wb_rd_idx, wb_rd_we, wb_result, interrupt_inhibit
    );
endinterface

// File: rtl/csr_commit_pipe.sv
// Fixed-latency CSR commit pipeline (E1 -> E2 -> WB) with exception merge, squash and interrupt inhibit.
// Latency: issue at cycle N commits at N+3; one instruction per cycle.
// No backpressure: never stalls; exceptions and squash kill younger slots instead.
module csr_commit_pipe #(
    parameter int unsigned EXC_HOLDOFF = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    csr_commit_pipe_if.slave  bus
);

    localparam logic [3:0] HOLDOFF_LOAD = 4'(EXC_HOLDOFF);
    localparam logic [5:0] EXC_ILLEGAL  = 6'h02;

    // E1 slot: metadata only
    logic        e1_vld;
    logic [31:0] e1_pc;
    logic [11:0] e1_csr_addr;
    logic [4:0]  e1_rd;

    // E2 slot: metadata plus the registered CSR result
    logic        e2_vld;
    logic [31:0] e2_pc;
    logic [11:0] e2_csr_addr;
    logic [4:0]  e2_rd;
    logic [31:0] e2_value;
    logic        e2_write;
    logic [31:0] e2_wdata;
    logic [5:0]  e2_exc;

    // WB slot: E2 contents with both exception sources merged
    logic        wb_vld;
    logic [31:0] wb_pc;
    logic [11:0] wb_csr_addr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;
    logic        wb_write;
    logic [31:0] wb_wdata;
    logic [5:0]  wb_exc;
    logic [31:0] wb_addr;

    logic [3:0]  holdoff_cnt;

    logic        exc_commit;
    logic        flush;
    logic        issue_acc;
    logic [5:0]  merged_exc;
    logic [31:0] merged_addr;

    // A committing exception and an external squash both kill everything younger than WB.
    assign exc_commit = wb_vld && (wb_exc != 6'd0);
    assign flush      = exc_commit || bus.squash;
    assign issue_acc  = bus.opcode_valid && !flush;

    // Merge exceptions: the CSR one is older so it wins; tval depends on which source fired.
    always_comb begin
        merged_exc  = 6'd0;
        merged_addr = 32'd0;
        if (e2_exc != 6'd0) begin
            merged_exc = e2_exc;
            if (e2_exc == EXC_ILLEGAL) begin
                merged_addr = e2_value;
            end
        end else if (bus.mem_exception_e2 != 6'd0) begin
            merged_exc  = bus.mem_exception_e2;
            merged_addr = bus.mem_addr_e2;
        end
    end

    // Slot valid bits advance every cycle; flush clears E1/E2 and stops E2 from reaching WB.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e1_vld <= 1'b0;
            e2_vld <= 1'b0;
            wb_vld <= 1'b0;
        end else begin
            e1_vld <= issue_acc;
            e2_vld <= e1_vld && !flush;
            wb_vld <= e2_vld && !flush;
        end
    end

    // E1 captures issue metadata for accepted instructions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e1_pc       <= 32'd0;
            e1_csr_addr <= 12'd0;
            e1_rd       <= 5'd0;
        end else if (issue_acc) begin
            e1_pc       <= bus.opcode_pc;
            e1_csr_addr <= bus.opcode_opcode[31:20];
            e1_rd       <= bus.opcode_rd_idx;
        end
    end

    // E2 pairs E1 metadata with the CSR result that arrives one cycle after issue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e2_pc       <= 32'd0;
            e2_csr_addr <= 12'd0;
            e2_rd       <= 5'd0;
            e2_value    <= 32'd0;
            e2_write    <= 1'b0;
            e2_wdata    <= 32'd0;
            e2_exc      <= 6'd0;
        end else if (e1_vld) begin
            e2_pc       <= e1_pc;
            e2_csr_addr <= e1_csr_addr;
            e2_rd       <= e1_rd;
            e2_value    <= bus.csr_result_e1_value;
            e2_write    <= bus.csr_result_e1_write;
            e2_wdata    <= bus.csr_result_e1_wdata;
            e2_exc      <= bus.csr_result_e1_exception;
        end
    end

    // WB captures E2 with the merged exception code and tval.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_pc       <= 32'd0;
            wb_csr_addr <= 12'd0;
            wb_rd       <= 5'd0;
            wb_value    <= 32'd0;
            wb_write    <= 1'b0;
            wb_wdata    <= 32'd0;
            wb_exc      <= 6'd0;
            wb_addr     <= 32'd0;
        end else if (e2_vld) begin
            wb_pc       <= e2_pc;
            wb_csr_addr <= e2_csr_addr;
            wb_rd       <= e2_rd;
            wb_value    <= e2_value;
            wb_write    <= e2_write;
            wb_wdata    <= e2_wdata;
            wb_exc      <= merged_exc;
            wb_addr     <= merged_addr;
        end
    end

    // Holdoff counter reloads on every exception commit and otherwise counts down to zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            holdoff_cnt <= 4'd0;
        end else if (exc_commit) begin
            holdoff_cnt <= HOLDOFF_LOAD;
        end else if (holdoff_cnt != 4'd0) begin
            holdoff_cnt <= holdoff_cnt - 4'd1;
        end
    end

    // Writeback outputs are gated by the WB valid bit so an empty slot presents all zeros.
    assign bus.wb_valid                     = wb_vld;
    assign bus.wb_rd_idx                    = wb_vld ? wb_rd : 5'd0;
    assign bus.wb_result                    = wb_vld ? wb_value : 32'd0;
    assign bus.wb_rd_we                     = wb_vld && wb_write && (wb_exc == 6'd0) && (wb_rd != 5'd0);
    assign bus.csr_writeback_write          = wb_vld && wb_write && (wb_exc == 6'd0);
    assign bus.csr_writeback_waddr          = wb_vld ? wb_csr_addr : 12'd0;
    assign bus.csr_writeback_wdata          = wb_vld ? wb_wdata : 32'd0;
    assign bus.csr_writeback_exception      = wb_vld ? wb_exc : 6'd0;
    assign bus.csr_writeback_exception_pc   = wb_vld ? wb_pc : 32'd0;
    assign bus.csr_writeback_exception_addr = wb_vld ? wb_addr : 32'd0;
    assign bus.interrupt_inhibit            = e1_vld || e2_vld || wb_vld || (holdoff_cnt != 4'd0);

endmodule

// File: tb/tb_csr_commit_pipe.sv
// Directed bench for csr_commit_pipe: reset, single commit, back-to-back, exceptions, squash, holdoff.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// No backpressure exists; every check is at a fixed cycle offset from issue.
module tb_csr_commit_pipe;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   tests = 0;
    int   fails = 0;

    csr_commit_pipe_if bus();

    csr_commit_pipe #(.EXC_HOLDOFF(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        bus.opcode_valid            = 1'b0;
        bus.opcode_opcode           = 32'd0;
        bus.opcode_pc               = 32'd0;
        bus.opcode_rd_idx           = 5'd0;
        bus.csr_result_e1_value     = 32'd0;
        bus.csr_result_e1_write     = 1'b0;
        bus.csr_result_e1_wdata     = 32'd0;
        bus.csr_result_e1_exception = 6'd0;
        bus.mem_exception_e2        = 6'd0;
        bus.mem_addr_e2             = 32'd0;
        bus.squash                  = 1'b0;
    endtask

    task automatic issue(input logic [31:0] op, input logic [31:0] pc, input logic [4:0] rd);
        bus.opcode_valid  = 1'b1;
        bus.opcode_opcode = op;
        bus.opcode_pc     = pc;
        bus.opcode_rd_idx = rd;
    endtask

    task automatic result(input logic [31:0] val, input logic wr, input logic [31:0] wd, input logic [5:0] exc);
        bus.csr_result_e1_value     = val;
        bus.csr_result_e1_write     = wr;
        bus.csr_result_e1_wdata     = wd;
        bus.csr_result_e1_exception = exc;
    endtask

    task automatic test_reset();
        logic [5:0] flags;
        clr();
        rst_i = 1'b1;
        tick();
        tick();
        flags = {bus.wb_valid, bus.wb_rd_we, bus.csr_writeback_write, bus.interrupt_inhibit,
                 |bus.csr_writeback_exception, |bus.wb_result};
        tests++;
        if (flags !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000", flags);
        end
        rst_i = 1'b0;
        tick();
        tests++;
        if ({bus.wb_valid, bus.interrupt_inhibit, bus.csr_writeback_exception_pc} !== 34'd0) begin
            fails++;
            $display("FAIL post_reset: valid=%b inhibit=%b pc=%h expected all zero",
                     bus.wb_valid, bus.interrupt_inhibit, bus.csr_writeback_exception_pc);
        end
    endtask

    task automatic test_single_csrrw();
        clr(); issue(32'h30029073, 32'h100, 5'd0); tick();
        clr(); result(32'h1800, 1'b1, 32'hAA, 6'd0);
        tests++;
        if (bus.interrupt_inhibit !== 1'b1) begin
            fails++; $display("FAIL single_inhibit_e1: got %b expected 1", bus.interrupt_inhibit);
        end
        tick();
        clr(); tick();
        tests++;
        if ({bus.wb_valid, bus.csr_writeback_write, bus.wb_rd_we} !== 3'b110) begin
            fails++;
            $display("FAIL single_strobes: valid/write/rd_we got %b%b%b expected 110",
                     bus.wb_valid, bus.csr_writeback_write, bus.wb_rd_we);
        end
        tests++;
        if ({bus.csr_writeback_waddr, bus.csr_writeback_wdata} !== {12'h300, 32'hAA}) begin
            fails++;
            $display("FAIL single_waddr_wdata: got %h/%h expected 300/000000aa",
                     bus.csr_writeback_waddr, bus.csr_writeback_wdata);
        end
        tests++;
        if ({bus.csr_writeback_exception, bus.csr_writeback_exception_pc, bus.wb_result}
                !== {6'd0, 32'h100, 32'h1800}) begin
            fails++;
            $display("FAIL single_exc_pc_result: got %h/%h/%h expected 00/00000100/00001800",
                     bus.csr_writeback_exception, bus.csr_writeback_exception_pc, bus.wb_result);
        end
        tick();
        tests++;
        if ({bus.wb_valid, bus.interrupt_inhibit} !== 2'b00) begin
            fails++;
            $display("FAIL single_drain: valid/inhibit got %b%b expected 00", bus.wb_valid, bus.interrupt_inhibit);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops  [3];
        logic [31:0] vals [3];
        logic [11:0] addrs[3];
        ops[0] = 32'h300020F3; ops[1] = 32'h34102173; ops[2] = 32'h342021F3;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        addrs[0] = 12'h300; addrs[1] = 12'h341; addrs[2] = 12'h342;
        for (int c = 0; c < 5; c++) begin
            clr();
            if (c < 3) issue(ops[c], 32'(c * 4), 5'(c + 1));
            if (c >= 1 && c <= 3) result(vals[c-1], 1'b1, 32'h0, 6'd0);
            tick();
            if (c >= 2) begin
                tests++;
                if ({bus.wb_valid, bus.wb_rd_we, bus.wb_rd_idx, bus.csr_writeback_waddr}
                        !== {1'b1, 1'b1, 5'(c - 1), addrs[c-2]}) begin
                    fails++;
                    $display("FAIL b2b_ctl[%0d]: valid=%b rd_we=%b rd=%0d waddr=%h expected 1 1 %0d %h",
                             c - 2, bus.wb_valid, bus.wb_rd_we, bus.wb_rd_idx, bus.csr_writeback_waddr,
                             c - 1, addrs[c-2]);
                end
                tests++;
                if ({bus.csr_writeback_exception_pc, bus.wb_result} !== {32'(4 * (c - 2)), vals[c-2]}) begin
                    fails++;
                    $display("FAIL b2b_data[%0d]: pc=%h result=%h expected %h %h", c - 2,
                             bus.csr_writeback_exception_pc, bus.wb_result, 32'(4 * (c - 2)), vals[c-2]);
                end
            end
        end
        clr(); tick();
        tests++;
        if (bus.wb_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_end: wb_valid got %b expected 0", bus.wb_valid);
        end
    endtask

    task automatic test_illegal();
        clr(); issue(32'h3002A073, 32'h200, 5'd5); tick();
        clr(); result(32'h3002A073, 1'b0, 32'h0, 6'h02); issue(32'h30029073, 32'h204, 5'd6); tick();
        clr(); result(32'h77, 1'b1, 32'h1, 6'd0); tick();
        clr();
        tests++;
        if ({bus.wb_valid, bus.csr_writeback_exception, bus.csr_writeback_exception_addr, bus.csr_writeback_exception_pc}
                !== {1'b1, 6'h02, 32'h3002A073, 32'h200}) begin
            fails++;
            $display("FAIL illegal_commit: valid=%b exc=%h addr=%h pc=%h expected 1 02 3002a073 00000200",
                     bus.wb_valid, bus.csr_writeback_exception, bus.csr_writeback_exception_addr,
                     bus.csr_writeback_exception_pc);
        end
        tests++;
        if ({bus.csr_writeback_write, bus.wb_rd_we} !== 2'b00) begin
            fails++;
            $display("FAIL illegal_no_write: write/rd_we got %b%b expected 00", bus.csr_writeback_write, bus.wb_rd_we);
        end
        issue(32'h30029073, 32'h208, 5'd7);
        tick();
        clr(); result(32'h99, 1'b1, 32'h2, 6'd0);
        tests++;
        if ({bus.wb_valid, bus.interrupt_inhibit} !== 2'b01) begin
            fails++;
            $display("FAIL illegal_younger_killed: valid/inhibit got %b%b expected 01", bus.wb_valid, bus.interrupt_inhibit);
        end
        tick(); clr(); tick();
        tests++;
        if ({bus.wb_valid, bus.interrupt_inhibit} !== 2'b00) begin
            fails++;
            $display("FAIL illegal_issue_dropped: valid/inhibit got %b%b expected 00", bus.wb_valid, bus.interrupt_inhibit);
        end
    endtask

    task automatic test_mem_exception();
        for (int j = 0; j < 2; j++) begin
            clr(); issue(32'h30029073, 32'h300 + 32'(j * 4), 5'd1); tick();
            clr(); result(32'h55, 1'b1, 32'h0, (j == 1) ? 6'h03 : 6'h00); tick();
            clr(); bus.mem_exception_e2 = 6'h05; bus.mem_addr_e2 = 32'hDEAD0000; tick();
            clr();
            tests++;
            if ({bus.csr_writeback_exception, bus.csr_writeback_exception_addr}
                    !== ((j == 1) ? {6'h03, 32'h0} : {6'h05, 32'hDEAD0000})) begin
                fails++;
                $display("FAIL mem_exc_merge[%0d]: exc=%h addr=%h", j,
                         bus.csr_writeback_exception, bus.csr_writeback_exception_addr);
            end
            tests++;
            if ({bus.wb_valid, bus.csr_writeback_write, bus.wb_rd_we} !== 3'b100) begin
                fails++;
                $display("FAIL mem_exc_strobes[%0d]: valid/write/rd_we got %b%b%b expected 100", j,
                         bus.wb_valid, bus.csr_writeback_write, bus.wb_rd_we);
            end
            tick(); tick(); tick();
        end
        tests++;
        if (bus.interrupt_inhibit !== 1'b0) begin
            fails++; $display("FAIL mem_exc_idle: inhibit got %b expected 0", bus.interrupt_inhibit);
        end
    endtask

    task automatic test_squash();
        clr(); issue(32'h300020F3, 32'h400, 5'd1); tick();
        clr(); issue(32'h300020F3, 32'h404, 5'd2); result(32'hA1, 1'b1, 32'h0, 6'd0); tick();
        clr(); issue(32'h300020F3, 32'h408, 5'd3); result(32'hB2, 1'b1, 32'h0, 6'd0); tick();
        clr(); issue(32'h300020F3, 32'h40C, 5'd4); result(32'hC3, 1'b1, 32'h0, 6'd0);
        bus.squash = 1'b1;
        tests++;
        if ({bus.wb_valid, bus.wb_rd_we, bus.csr_writeback_exception_pc, bus.wb_result, bus.interrupt_inhibit}
                !== {1'b1, 1'b1, 32'h400, 32'hA1, 1'b1}) begin
            fails++;
            $display("FAIL squash_wb_commits: valid=%b rd_we=%b pc=%h result=%h inhibit=%b expected 1 1 400 a1 1",
                     bus.wb_valid, bus.wb_rd_we, bus.csr_writeback_exception_pc, bus.wb_result, bus.interrupt_inhibit);
        end
        tick();
        clr(); result(32'hD4, 1'b1, 32'h0, 6'd0);
        tests++;
        if ({bus.wb_valid, bus.interrupt_inhibit} !== 2'b00) begin
            fails++;
            $display("FAIL squash_cleared: valid/inhibit got %b%b expected 00", bus.wb_valid, bus.interrupt_inhibit);
        end
        tick(); clr(); tick();
        tests++;
        if (bus.wb_valid !== 1'b0) begin
            fails++; $display("FAIL squash_issue_dropped: wb_valid got %b expected 0", bus.wb_valid);
        end
    endtask

    task automatic test_holdoff_reset();
        logic [3:0] seen;
        // exception commit coincides with a squash: commit still happens, counter still loads
        clr(); issue(32'h30029073, 32'h500, 5'd1); tick();
        clr(); result(32'h0, 1'b0, 32'h0, 6'h03); tick();
        clr(); tick();
        bus.squash = 1'b1;
        seen[3] = bus.interrupt_inhibit;
        tests++;
        if ({bus.wb_valid, bus.csr_writeback_exception} !== {1'b1, 6'h03}) begin
            fails++;
            $display("FAIL holdoff_commit: valid=%b exc=%h expected 1 03", bus.wb_valid, bus.csr_writeback_exception);
        end
        tick(); clr();
        seen[2] = bus.interrupt_inhibit;
        tick();
        seen[1] = bus.interrupt_inhibit;
        tick();
        seen[0] = bus.interrupt_inhibit;
        tests++;
        if (seen !== 4'b1110) begin
            fails++; $display("FAIL holdoff_window: inhibit sequence got %b expected 1110", seen);
        end
        // reset in the middle of a holdoff window
        clr(); issue(32'h30029073, 32'h600, 5'd2); tick();
        clr(); result(32'h0, 1'b0, 32'h0, 6'h03); tick();
        clr(); tick();
        tick();
        tests++;
        if ({bus.wb_valid, bus.interrupt_inhibit} !== 2'b01) begin
            fails++;
            $display("FAIL holdoff_pre_reset: valid/inhibit got %b%b expected 01", bus.wb_valid, bus.interrupt_inhibit);
        end
        rst_i = 1'b1;
        #1;
        tests++;
        if ({bus.wb_valid, bus.interrupt_inhibit, bus.csr_writeback_exception} !== 8'd0) begin
            fails++;
            $display("FAIL holdoff_async_reset: valid=%b inhibit=%b exc=%h expected all zero",
                     bus.wb_valid, bus.interrupt_inhibit, bus.csr_writeback_exception);
        end
        tick();
        rst_i = 1'b0;
        tick();
        tests++;
        if (bus.interrupt_inhibit !== 1'b0) begin
            fails++; $display("FAIL holdoff_after_reset: inhibit got %b expected 0", bus.interrupt_inhibit);
        end
    endtask

    initial begin
        clr();
        test_reset();
        test_single_csrrw();
        test_back_to_back();
        test_illegal();
        test_mem_exception();
        test_squash();
        test_holdoff_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_commit_pipe.md
# csr_commit_pipe

Fixed-latency commit pipeline between the CSR execute unit and the CSR register file write port. Tracks each issued instruction's PC, opcode and rd through the E1, E2 and WB slots, and aligns it with the registered CSR result that arrives one cycle after issue. It merges late memory exceptions in E2 and drives the CSR writeback and exception-commit bus. It also squashes younger instructions behind a committing exception and generates the interrupt-inhibit signal.

## Interface
- EXC_HOLDOFF, 2: cycles `interrupt_inhibit_o` stays high after an exception commits (1..15).
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- opcode_valid_i  in  1  instruction issued this cycle (same strobe the CSR unit sees).
- opcode_opcode_i  in  32  issued opcode.
- opcode_pc_i  in  32  issued PC.
- opcode_rd_idx_i  in  5  destination register.
- csr_result_e1_value_i  in  32  CSR read value, or the faulting opcode; valid the cycle after issue.
- csr_result_e1_write_i  in  1  CSR access succeeded; rd and CSR writes are permitted.
- csr_result_e1_wdata_i  in  32  value to write to the CSR.
- csr_result_e1_exception_i  in  6  early exception code; 0 means none.
- mem_exception_e2_i  in  6  LSU exception for the instruction currently in E2.
- mem_addr_e2_i  in  32  LSU faulting address.
- squash_i  in  1  pipeline flush from branch/redirect.
- csr_writeback_write_o  out  1  CSR write strobe.
- csr_writeback_waddr_o  out  12  CSR address, taken from opcode[31:20].
- csr_writeback_wdata_o  out  32  CSR write data.
- csr_writeback_exception_o  out  6  committed exception code.
- csr_writeback_exception_pc_o  out  32  PC of the excepting instruction.
- csr_writeback_exception_addr_o  out  32  tval value.
- wb_valid_o  out  1  instruction commits this cycle.
- wb_rd_idx_o  out  5  rd of the committing instruction.
- wb_rd_we_o  out  1  write `wb_result_o` to rd.
- wb_result_o  out  32  CSR read value to write to rd.
- interrupt_inhibit_o  out  1  blocks interrupt launch.

## Operation
- Slots: E1 holds metadata only, loaded on `opcode_valid_i`. E2 holds metadata plus the CSR result, loaded from E1 and the `csr_result_e1_*` inputs. WB holds the E2 contents with the exceptions merged. Each slot has its own valid bit. The pipeline never stalls; the issue stage must not issue when downstream cannot accept.
- Exception merge at E2→WB: if the CSR exception is nonzero, use it. Otherwise use `mem_exception_e2_i`. The CSR exception has priority because it is older.
- Exception address at E2→WB:
  - CSR exception = 6'h02 (illegal instruction): `csr_result_e1_value`, i.e. the opcode.
  - Exception taken from the memory source: `mem_addr_e2_i`.
  - Otherwise: 0.
- WB outputs are combinational from the WB slot. When the slot is invalid, all outputs are 0.
- `csr_writeback_write_o` = WB valid & write & exception==0.
- `wb_rd_we_o` = WB valid & write & exception==0 & rd≠0.
- `csr_writeback_exception_o` and `_pc_o` are presented whenever WB is valid; the code is 0 when there is no exception.
- Exception commit: when WB is valid with a nonzero exception, the E1 and E2 valid bits clear at the next edge. Any `opcode_valid_i` in the same cycle is also dropped. The holdoff counter loads EXC_HOLDOFF.
- `squash_i`: clears the E1 and E2 valid bits at the edge and drops a same-cycle issue. The instruction in WB still commits; it is older than the squash.
- `interrupt_inhibit_o` is combinational: (E1 | E2 | WB valid) | (holdoff counter ≠ 0). The counter decrements to 0 and saturates there.
- Arithmetic: no width extension. All fields are passed through bit-exact.

## Timing
- Issue at cycle N → E1 slot N+1 (CSR result present) → E2 slot N+2 (mem exception sampled) → WB outputs at N+3. The pipeline accepts one instruction per cycle.
- Reset: all valid bits 0, all data registers 0, holdoff counter 0. Every output is 0 during and after reset until the first commit.
- Reset mid-flight discards all slots immediately, because the reset is asynchronous.
- Simultaneous squash and WB exception: the instruction in WB commits, E1/E2 are cleared once, and the holdoff counter loads.
- A new exception while the counter is nonzero reloads the counter to EXC_HOLDOFF.

## Test plan
- Single csrrw, pc=0x100, opcode=0x30029073, CSR value 0x1800, write=1, wdata=0xAA → at N+3: `csr_writeback_write_o`=1, waddr=0x300, wdata=0xAA, wb_rd_we_o=0 (rd=0), exception=0.
- Back-to-back issues N, N+1, N+2 (pcs 0x0/0x4/0x8) → three consecutive commits at N+3..N+5 in order, each with its matching pc and value.
- Illegal CSR access: exception input 0x02, value=0x3002A073 → exception_o=0x02, exception_addr_o=0x3002A073, no CSR or rd write. The following issued instruction is squashed and never commits.
- Mem exception 0x05 with addr 0xDEAD0000 in E2, CSR exception 0 → exception_o=0x05, addr=0xDEAD0000. With CSR exception 0x03 present in the same case → exception_o=0x03, addr=0.
- `squash_i` pulsed with instructions in E1, E2 and WB → only the WB instruction commits. `interrupt_inhibit_o` falls the cycle after the WB commit.
- Exception commit with EXC_HOLDOFF=2 and an empty pipeline → `interrupt_inhibit_o` is high for exactly 2 cycles after the commit cycle. Asserting `rst_i` mid-holdoff drops it immediately.
